prog_lut_neuron: RTL and testbench

Runtime-programmable counterpart to the generated fixed-ROM LUT neurons: it accepts a truth table over a streaming configuration port, writes it into a 2^IN_BITS x OUT_BITS register table, then serves registered lookups with the same M0/M1 port semantics as a synthesized neuron. It sits in the ensemble datapath wherever a layer-1 neuron must be retrained or swapped without resynthesis, with the configuration stream driven from the host-side loader.

---
 rtl/prog_lut_neuron_if.sv | 34 +++
 rtl/prog_lut_neuron.sv | 141 ++++++++++++++
 tb/tb_prog_lut_neuron.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/prog_lut_neuron_if.sv
// prog_lut_neuron_if: bundles the configuration stream and lookup ports of a
// runtime-programmable LUT neuron.
//   master : host/datapath side (drives cfg_valid/cfg_data/cfg_last, M0/M0_valid)
//   slave  : neuron side (drives cfg_ready/cfg_done/cfg_err/armed, M1/M1_valid/M1_drop)
interface prog_lut_neuron_if #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned CFG_W    = 8
);
    // Configuration stream
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                cfg_done;
    logic                cfg_err;
    logic                armed;
    // Lookup path
    logic [IN_BITS-1:0]  M0;
    logic                M0_valid;
    logic [OUT_BITS-1:0] M1;
    logic                M1_valid;
    logic                M1_drop;

    modport master (
        output cfg_valid, cfg_data, cfg_last, M0, M0_valid,
        input  cfg_ready, cfg_done, cfg_err, armed, M1, M1_valid, M1_drop
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, M0, M0_valid,
        output cfg_ready, cfg_done, cfg_err, armed, M1, M1_valid, M1_drop
    );
endinterface

// File: rtl/prog_lut_neuron.sv
// prog_lut_neuron: LUT neuron whose truth table is loaded at runtime over a
// streaming configuration port, then serves registered 1-cycle lookups.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset; clears the table and all outputs
//   bus   : prog_lut_neuron_if.slave (config stream + M0/M1 lookup port)
// Table layout: flat vector, entry e at [e*OUT_BITS +: OUT_BITS], config word k
// at [k*CFG_W +: CFG_W].
module prog_lut_neuron #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned CFG_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    prog_lut_neuron_if.slave bus
);

    localparam int unsigned TBITS  = (1 << IN_BITS) * OUT_BITS;
    localparam int unsigned NWORDS = TBITS / CFG_W;
    localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    // A one-word table is complete on its very first beat.
    localparam logic SINGLE = (NWORDS == 1);

    typedef enum logic [1:0] {StEmpty, StLoading, StArmed, StErr} state_e;

    state_e              state_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [TBITS-1:0]    table_q;
    logic                cfg_ready_q;
    logic                armed_q;
    logic                cfg_done_q;
    logic                cfg_err_q;
    logic [OUT_BITS-1:0] m1_q;
    logic                m1_valid_q;
    logic                m1_drop_q;

    logic                beat;
    logic                at_final;
    logic [OUT_BITS-1:0] lookup;

    assign beat     = bus.cfg_valid && cfg_ready_q;
    assign at_final = (wcnt_q == WCNT_W'(NWORDS - 1));
    assign lookup   = table_q[32'(bus.M0) * OUT_BITS +: OUT_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            wcnt_q      <= '0;
            table_q     <= '0;
            cfg_ready_q <= 1'b1;
            armed_q     <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            m1_q        <= '0;
            m1_valid_q  <= 1'b0;
            m1_drop_q   <= 1'b0;
        end else begin
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;

            // Lookup sees the table as it stood before any write this cycle,
            // so a lookup racing the first beat of a reload uses the old table.
            if (bus.M0_valid) begin
                if (state_q == StArmed) begin
                    m1_q       <= lookup;
                    m1_valid_q <= 1'b1;
                    m1_drop_q  <= 1'b0;
                end else begin
                    m1_valid_q <= 1'b0;
                    m1_drop_q  <= 1'b1;
                end
            end else begin
                m1_valid_q <= 1'b0;
                m1_drop_q  <= 1'b0;
            end

            case (state_q)
                StEmpty, StArmed: begin
                    if (beat) begin
                        table_q[0 +: CFG_W] <= bus.cfg_data;
                        armed_q             <= 1'b0;
                        wcnt_q              <= '0;
                        // cfg_last must coincide exactly with the final word.
                        if (bus.cfg_last != SINGLE) begin
                            state_q     <= StErr;
                            cfg_ready_q <= 1'b0;
                            cfg_err_q   <= 1'b1;
                        end else if (SINGLE) begin
                            state_q    <= StArmed;
                            armed_q    <= 1'b1;
                            cfg_done_q <= 1'b1;
                        end else begin
                            state_q <= StLoading;
                            wcnt_q  <= WCNT_W'(1);
                        end
                    end
                end
                StLoading: begin
                    if (beat) begin
                        table_q[32'(wcnt_q) * CFG_W +: CFG_W] <= bus.cfg_data;
                        if (bus.cfg_last != at_final) begin
                            state_q     <= StErr;
                            cfg_ready_q <= 1'b0;
                            cfg_err_q   <= 1'b1;
                            wcnt_q      <= '0;
                        end else if (at_final) begin
                            state_q    <= StArmed;
                            armed_q    <= 1'b1;
                            cfg_done_q <= 1'b1;
                            wcnt_q     <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                StErr: begin
                    // Single-cycle error state; table kept but never served.
                    state_q     <= StEmpty;
                    cfg_ready_q <= 1'b1;
                    wcnt_q      <= '0;
                end
                default: begin
                    state_q     <= StEmpty;
                    cfg_ready_q <= 1'b1;
                    armed_q     <= 1'b0;
                    wcnt_q      <= '0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_done  = cfg_done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.armed     = armed_q;
    assign bus.M1        = m1_q;
    assign bus.M1_valid  = m1_valid_q;
    assign bus.M1_drop   = m1_drop_q;

endmodule

// File: tb/tb_prog_lut_neuron.sv
// Directed self-checking bench for prog_lut_neuron (IN_BITS=8, OUT_BITS=1, CFG_W=8).
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_prog_lut_neuron;

    localparam int unsigned IN_BITS  = 8;
    localparam int unsigned OUT_BITS = 1;
    localparam int unsigned CFG_W    = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    prog_lut_neuron_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) bus ();

    prog_lut_neuron #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Stream words first..first+count-1 all holding val; cfg_last on word last_at.
    task automatic load(input logic [7:0] val, input int first, input int count,
                        input int last_at);
        for (int k = first; k < first + count; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = val;
            bus.cfg_last  = (k == last_at);
            cycle();
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    // Issue one lookup and check the result one cycle later (leaves M0_valid high).
    task automatic lookup(input string tag, input logic [7:0] addr, input logic exp);
        bus.M0       = addr;
        bus.M0_valid = 1'b1;
        cycle();
        check(tag, 32'(bus.M1), 32'(exp));
        check({tag, "_valid"}, 32'(bus.M1_valid), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.cfg_ready), 1);
        check({tag, "_armed"}, 32'(bus.armed), 0);
        check({tag, "_done"},  32'(bus.cfg_done), 0);
        check({tag, "_err"},   32'(bus.cfg_err), 0);
        check({tag, "_m1"},    32'(bus.M1), 0);
        check({tag, "_m1v"},   32'(bus.M1_valid), 0);
        check({tag, "_drop"},  32'(bus.M1_drop), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.M0        = '0;
        bus.M0_valid  = 1'b0;
        #12;
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Lookup while empty is dropped
        bus.M0       = 8'h40;
        bus.M0_valid = 1'b1;
        cycle();
        check("empty_drop", 32'(bus.M1_drop), 1);
        check("empty_m1v", 32'(bus.M1_valid), 0);
        check("empty_armed", 32'(bus.armed), 0);
        check("empty_ready", 32'(bus.cfg_ready), 1);
        bus.M0_valid = 1'b0;
        cycle();
        check("drop_pulse", 32'(bus.M1_drop), 0);

        // Full load of 0xAA: entry e = bit (e%8) of 0xAA
        load(8'hAA, 0, 31, 31);
        check("aa_done_early", 32'(bus.cfg_done), 0);
        load(8'hAA, 31, 1, 31);
        check("aa_done", 32'(bus.cfg_done), 1);
        check("aa_armed", 32'(bus.armed), 1);
        lookup("aa_m0", 8'd0, 1'b0);
        check("aa_done_pulse", 32'(bus.cfg_done), 0);
        lookup("aa_m1", 8'd1, 1'b1);
        lookup("aa_m2", 8'd2, 1'b0);
        lookup("aa_m255", 8'd255, 1'b1);
        bus.M0_valid = 1'b0;
        cycle();
        check("aa_idle_m1v", 32'(bus.M1_valid), 0);

        // Early cfg_last on word 5
        load(8'h11, 0, 6, 5);
        check("early_err", 32'(bus.cfg_err), 1);
        check("early_ready", 32'(bus.cfg_ready), 0);
        check("early_armed", 32'(bus.armed), 0);
        check("early_done", 32'(bus.cfg_done), 0);
        bus.M0       = 8'd1;
        bus.M0_valid = 1'b1;
        cycle();
        check("err_drop", 32'(bus.M1_drop), 1);
        check("err_m1v", 32'(bus.M1_valid), 0);
        check("err_ready_back", 32'(bus.cfg_ready), 1);
        check("err_pulse", 32'(bus.cfg_err), 0);
        bus.M0_valid = 1'b0;
        load(8'h0F, 0, 32, 31);
        check("0f_done", 32'(bus.cfg_done), 1);
        check("0f_armed", 32'(bus.armed), 1);
        lookup("0f_m3", 8'd3, 1'b1);
        lookup("0f_m4", 8'd4, 1'b0);
        bus.M0_valid = 1'b0;

        // Word 31 without cfg_last
        load(8'h0F, 0, 32, -1);
        check("nolast_err", 32'(bus.cfg_err), 1);
        check("nolast_armed", 32'(bus.armed), 0);
        check("nolast_done", 32'(bus.cfg_done), 0);
        cycle();
        check("nolast_ready_back", 32'(bus.cfg_ready), 1);

        // Lookup racing the first beat of a reload reads the old table
        load(8'hFF, 0, 32, 31);
        check("ff_done", 32'(bus.cfg_done), 1);
        bus.M0        = 8'd7;
        bus.M0_valid  = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h00;
        bus.cfg_last  = 1'b0;
        cycle();
        check("race_m1", 32'(bus.M1), 1);
        check("race_m1v", 32'(bus.M1_valid), 1);
        check("race_armed", 32'(bus.armed), 0);
        bus.M0_valid = 1'b0;
        load(8'h00, 1, 31, 31);
        check("zero_done", 32'(bus.cfg_done), 1);
        lookup("zero_m7", 8'd7, 1'b0);
        bus.M0_valid = 1'b0;

        // Asynchronous reset in the middle of a load
        load(8'hFF, 0, 32, 31);
        lookup("pre_rst_m9", 8'd9, 1'b1);
        bus.M0_valid = 1'b0;
        load(8'h55, 0, 11, -1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        #3 rst_n = 1'b1;
        bus.M0       = 8'd2;
        bus.M0_valid = 1'b1;
        cycle();
        check("post_rst_drop", 32'(bus.M1_drop), 1);
        bus.M0_valid = 1'b0;
        load(8'h3C, 0, 31, 31);
        check("3c_done_31", 32'(bus.cfg_done), 0);
        check("3c_armed_31", 32'(bus.armed), 0);
        load(8'h3C, 31, 1, 31);
        check("3c_done_32", 32'(bus.cfg_done), 1);
        check("3c_armed_32", 32'(bus.armed), 1);
        lookup("3c_m2", 8'd2, 1'b1);
        lookup("3c_m8", 8'd8, 1'b0);
        lookup("3c_m13", 8'd13, 1'b1);
        lookup("3c_m255", 8'd255, 1'b0);
        bus.M0_valid = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
